fp_div64_seq: RTL and testbench

Sequential 64-bit unsigned radix-2 restoring divider for the FP divide functional unit; the inverse datapath of the 64×64→128 Wallace multiplier. Divides a 128-bit dividend by a 64-bit divisor, producing a 64-bit quotient and a 64-bit remainder, one quotient bit per cycle. It sits between the divide reservation station, which supplies the mantissa operands and a tag, and the common data bus arbiter. Valid/ready handshakes are used on both sides.

---
 rtl/fp_div64_seq_pkg.sv | 19 +
 rtl/fp_div64_seq_div_step.sv | 25 ++
 rtl/fp_div64_seq.sv | 131 +++++++++++++
 tb/tb_fp_div64_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div64_seq_pkg.sv
// Shared constants and types for the sequential FP mantissa divider.
package fp_div64_seq_pkg;

    localparam int unsigned DivW     = 64;
    localparam int unsigned DivSteps = 64;
    localparam int unsigned CntW     = $clog2(DivSteps);

    // Exception flag bit positions, shared with the FP exception logic.
    localparam int unsigned FlagDbz = 0;
    localparam int unsigned FlagOvf = 1;
    localparam int unsigned FlagW   = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/fp_div64_seq_div_step.sv
// One combinational restoring-division iteration.
// The partial remainder is always below the divisor, so its 65th bit is zero on entry and exit;
// only the low 64 bits are carried across the port while the subtract runs on 65 bits.
module fp_div64_seq_div_step
    import fp_div64_seq_pkg::*;
(
    input  logic [DivW-1:0] r_i,
    input  logic            bit_i,
    input  logic [DivW-1:0] divisor_i,
    output logic [DivW-1:0] r_o,
    output logic            q_bit_o
);

    logic [DivW:0] shifted;
    logic [DivW:0] trial;

    // Trial subtract; a set sign bit means the divisor did not fit.
    always_comb begin
        shifted = {r_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        q_bit_o = ~trial[DivW];
        r_o     = q_bit_o ? trial[DivW-1:0] : shifted[DivW-1:0];
    end

endmodule

// File: rtl/fp_div64_seq.sv
// Sequential 128/64 unsigned restoring divider, one quotient bit per cycle.
module fp_div64_seq
    import fp_div64_seq_pkg::*;
#(
    parameter int unsigned TagW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2*DivW-1:0] dividend_i,
    input  logic [DivW-1:0]   divisor_i,
    input  logic [TagW-1:0]   in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DivW-1:0]   quotient_o,
    output logic [DivW-1:0]   remainder_o,
    output logic [TagW-1:0]   out_tag_o,
    output logic              dbz_o,
    output logic              ovf_o
);

    div_state_e          state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [DivW-1:0]     r_q, r_d;
    logic [DivW-1:0]     q_q, q_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [TagW-1:0]     tag_q, tag_d;
    logic [FlagW-1:0]    flags_q, flags_d;

    logic [DivW-1:0]     step_r;
    logic                step_q;

    fp_div64_seq_div_step u_div_step (
        .r_i       (r_q),
        .bit_i     (q_q[DivW-1]),
        .divisor_i (div_q),
        .r_o       (step_r),
        .q_bit_o   (step_q)
    );

    // Next-state logic; flush overrides every other transition and blocks accepts.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        div_d   = div_q;
        tag_d   = tag_q;
        flags_d = flags_q;

        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        tag_d   = in_tag_i;
                        div_d   = divisor_i;
                        flags_d = '0;
                        if (divisor_i == '0) begin
                            q_d              = '1;
                            r_d              = dividend_i[DivW-1:0];
                            flags_d[FlagDbz] = 1'b1;
                            state_d          = StDone;
                        end else if (dividend_i[2*DivW-1:DivW] >= divisor_i) begin
                            // Quotient would not fit in 64 bits.
                            q_d              = '1;
                            r_d              = dividend_i[DivW-1:0];
                            flags_d[FlagOvf] = 1'b1;
                            state_d          = StDone;
                        end else begin
                            r_d     = dividend_i[2*DivW-1:DivW];
                            q_d     = dividend_i[DivW-1:0];
                            count_d = '0;
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    r_d     = step_r;
                    q_d     = {q_q[DivW-2:0], step_q};
                    count_d = count_q + 1'b1;
                    if (count_q == CntW'(DivSteps - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            tag_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            div_q   <= div_d;
            tag_q   <= tag_d;
            flags_q <= flags_d;
        end
    end

    // Handshake and result outputs, all driven from registers.
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        quotient_o  = q_q;
        remainder_o = r_q;
        out_tag_o   = tag_q;
        dbz_o       = flags_q[FlagDbz];
        ovf_o       = flags_q[FlagOvf];
    end

endmodule

// File: tb/tb_fp_div64_seq.sv
// Self-checking bench for fp_div64_seq against a plain-arithmetic division model.
module tb_fp_div64_seq;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] dividend;
    logic [63:0]  divisor;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  quotient;
    logic [63:0]  remainder;
    logic [3:0]   out_tag;
    logic         dbz;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    fp_div64_seq #(.TagW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .out_tag_o   (out_tag),
        .dbz_o       (dbz),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordinary 128-bit division plus the exception rules.
    function automatic void model(input logic [127:0] n, input logic [63:0] d,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output logic ov, output int lat);
        logic [127:0] qq;
        logic [127:0] rr;
        if (d == 64'd0) begin
            q = '1; r = n[63:0]; dz = 1'b1; ov = 1'b0; lat = 1;
        end else if (n[127:64] >= d) begin
            q = '1; r = n[63:0]; dz = 1'b0; ov = 1'b1; lat = 1;
        end else begin
            qq = n / {64'd0, d};
            rr = n % {64'd0, d};
            q = qq[63:0]; r = rr[63:0]; dz = 1'b0; ov = 1'b0; lat = 65;
        end
    endfunction

    // Drive one accept; lat counts rising edges from the accept edge (inclusive) to out_valid.
    task automatic start_op(input logic [127:0] n, input logic [63:0] d, input logic [3:0] t,
                            output int lat);
        @(negedge clk);
        dividend = n; divisor = d; in_tag = t; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic ack_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [127:0] n, input logic [63:0] d,
                                 input logic [3:0] t);
        logic [63:0] eq, er;
        logic        edz, eov;
        int          elat, lat;
        model(n, d, eq, er, edz, eov, elat);
        start_op(n, d, t, lat);
        total++;
        if (lat !== elat) begin
            bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat);
        end
        total++;
        if (quotient !== eq) begin
            bad++; $display("FAIL %s quotient got=%h exp=%h", name, quotient, eq);
        end
        total++;
        if (remainder !== er) begin
            bad++; $display("FAIL %s remainder got=%h exp=%h", name, remainder, er);
        end
        total++;
        if (out_tag !== t) begin
            bad++; $display("FAIL %s tag got=%h exp=%h", name, out_tag, t);
        end
        total++;
        if ({dbz, ovf} !== {edz, eov}) begin
            bad++; $display("FAIL %s flags got=%b%b exp=%b%b", name, dbz, ovf, edz, eov);
        end
        ack_op();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL %s post_ack got=%b%b exp=01", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, dbz, ovf} !== 4'b1000 || quotient !== 64'd0 ||
            remainder !== 64'd0 || out_tag !== 4'd0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h tag=%h dbz=%b ovf=%b exp=1,0,0,0,0,0,0",
                     in_ready, out_valid, quotient, remainder, out_tag, dbz, ovf);
        end
    endtask

    task automatic test_directed();
        run_and_check("basic_100_7", 128'd100, 64'd7, 4'd3);
        run_and_check("max_quot", {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF},
                      64'hFFFF_FFFF_FFFF_FFFF, 4'd9);
        run_and_check("div_by_one", {64'h0, 64'hDEAD_BEEF_0123_4567}, 64'd1, 4'd1);
        run_and_check("hi_just_below", {64'd4, 64'h8000_0000_0000_0001}, 64'd5, 4'd2);
    endtask

    task automatic test_exceptions();
        run_and_check("dbz", 128'h1234, 64'd0, 4'd5);
        run_and_check("ovf_equal", {64'd5, 64'd0}, 64'd5, 4'd6);
        run_and_check("ovf_greater", {64'hFFFF_0000_0000_0000, 64'd77}, 64'd3, 4'd7);
    endtask

    task automatic test_random();
        logic [127:0] n;
        logic [63:0]  d;
        logic [63:0]  hi;
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: d = {$urandom, $urandom};
                1: d = {32'd0, $urandom};
                2: d = 64'($urandom_range(1, 255));
                default: d = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            endcase
            if (d == 64'd0) d = 64'd1;
            hi = {$urandom, $urandom};
            if (i % 7 != 6) hi = hi % d;  // mostly in range, occasionally overflow
            n = {hi, $urandom, $urandom};
            run_and_check($sformatf("rand%0d", i), n, d, 4'($urandom));
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] eq, er, q0, r0;
        logic [3:0]  t0;
        logic        edz, eov;
        int          elat, lat;
        model(128'd123456789, 64'd1000, eq, er, edz, eov, elat);
        start_op(128'd123456789, 64'd1000, 4'hA, lat);
        total++;
        if (quotient !== eq || remainder !== er || lat !== elat) begin
            bad++; $display("FAIL bp_result got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d",
                            quotient, remainder, lat, eq, er, elat);
        end
        q0 = quotient; r0 = remainder; t0 = out_tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = {64'd0, $urandom, $urandom}; divisor = 64'd3;
            in_tag = 4'h5;
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, in_ready} !== 2'b10 || quotient !== eq || remainder !== er ||
                out_tag !== 4'hA) begin
                bad++; $display("FAIL bp_hold%0d got vld=%b rdy=%b q=%h r=%h tag=%h exp 1,0,%h,%h,a",
                                i, out_valid, in_ready, quotient, remainder, out_tag, eq, er);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release got vld=%b rdy=%b exp 0,1", out_valid, in_ready);
        end
        // Held operands must not have been disturbed by the ignored pulses.
        total++;
        if (quotient !== q0 || remainder !== r0 || out_tag !== t0) begin
            bad++; $display("FAIL bp_after got q=%h r=%h tag=%h exp q=%h r=%h tag=%h",
                            quotient, remainder, out_tag, q0, r0, t0);
        end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        dividend = 128'd99999; divisor = 64'd17; in_tag = 4'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; dividend = 128'd50; divisor = 64'd0; in_tag = 4'd8;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL flush_idle got vld=%b rdy=%b exp 0,1", out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL flush_no_result got busy_cycles=%0d exp 0", seen);
        end
        run_and_check("after_flush", 128'd99999, 64'd17, 4'd4);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        dividend = 128'hFFFF_0000_1234; divisor = 64'd13; in_tag = 4'hC; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, dbz, ovf} !== 4'b1000 || quotient !== 64'd0 ||
            remainder !== 64'd0 || out_tag !== 4'd0) begin
            bad++; $display("FAIL async_reset got rdy=%b vld=%b q=%h r=%h tag=%h exp 1,0,0,0,0",
                            in_ready, out_valid, quotient, remainder, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("after_reset", 128'd1000, 64'd10, 4'd2);
        total++;
        if (quotient !== 64'd100 || remainder !== 64'd0) begin
            bad++; $display("FAIL after_reset_const got q=%0d r=%0d exp q=100 r=0",
                            quotient, remainder);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exceptions();
        test_back_pressure();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
